multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 43 ++++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared state encoding, opcode and ALU-op constants for the multicycle controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_controller_pkg;

  // Controller states; the encoding is exported on state_o for debug
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Supported instruction opcodes (RV32 major opcodes)
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation selects
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Width of the memory wait counter
  localparam int WAIT_W = 8;

  // True when the opcode is one this controller can execute
  function automatic logic isLegalOpcode(input logic [6:0] op, input logic branchEn);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE: legal = 1'b1;
      OP_BRANCH:                     legal = branchEn;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts cycles spent waiting on mem_ready in FETCH/MEM and flags a timeout.
// Latency: count registered; timedOut is a combinational compare of the registered count.
// Backpressure: none; it only observes the handshake.
module mem_wait_timer
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic waitActive,
  input  logic memReady,
  output logic timedOut
);

  localparam logic [WAIT_W-1:0] LIMIT   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] ONE     = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] SAT_MAX = '1;

  logic [WAIT_W-1:0] waitCount;

  // Count wait cycles; any cycle outside a memory state, or a completed handshake,
  // returns the count to zero so every FETCH/MEM entry starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCount <= '0;
    end else if (!waitActive || memReady) begin
      waitCount <= '0;
    end else if (waitCount != SAT_MAX) begin
      waitCount <= waitCount + ONE;
    end
  end

  // The count equals the number of wait cycles already spent, so MEM_TIMEOUT waits
  // are tolerated and the cycle after them still gets one chance to see mem_ready
  assign timedOut = (waitCount >= LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB/FAULT) driving datapath strobes.
// Latency: R/I 4 cycles, load 5, store 4, branch 3 with zero memory wait.
// Backpressure: FETCH and MEM stall on mem_ready low; timeout after MEM_TIMEOUT waits forces FAULT.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit BRANCH_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] ALUOp,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       fault,
  output logic [2:0] state_o
);

  state_t     state;
  logic [6:0] opcodeQ;
  logic       faultQ;
  logic       waitActive;
  logic       timedOut;
  logic       isRType;
  logic       isLoad;
  logic       isStore;
  logic       isBranch;

  // Instruction class decoded from the latched opcode only, never from the live input
  assign isRType  = (opcodeQ == OP_R);
  assign isLoad   = (opcodeQ == OP_LOAD);
  assign isStore  = (opcodeQ == OP_STORE);
  assign isBranch = BRANCH_EN && (opcodeQ == OP_BRANCH);

  assign waitActive = (state == S_FETCH) || (state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) uWaitTimer (
    .clk       (clk),
    .reset     (reset),
    .waitActive(waitActive),
    .memReady  (mem_ready),
    .timedOut  (timedOut)
  );

  // State register, opcode latch and sticky fault flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      opcodeQ <= '0;
      faultQ  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (timedOut) begin
            state  <= S_FAULT;
            faultQ <= 1'b1;
          end
        end
        S_DECODE: begin
          opcodeQ <= opcode;
          if (isLegalOpcode(opcode, BRANCH_EN)) begin
            state <= S_EXEC;
          end else begin
            state  <= S_FAULT;
            faultQ <= 1'b1;
          end
        end
        S_EXEC: begin
          if (isBranch) begin
            state <= S_FETCH;
          end else if (isLoad || isStore) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= isLoad ? S_WB : S_FETCH;
          end else if (timedOut) begin
            state  <= S_FAULT;
            faultQ <= 1'b1;
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        S_FAULT: begin
          state  <= S_FAULT;
          faultQ <= 1'b1;
        end
        default: begin
          state  <= S_FAULT;
          faultQ <= 1'b1;
        end
      endcase
    end
  end

  // Datapath strobes from state, latched opcode, zero and mem_ready; all held low in reset
  always_comb begin
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = ALU_ADD;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        S_EXEC: begin
          if (isRType) begin
            ALUOp = ALU_FUNCT;
          end else if (isBranch) begin
            ALUOp   = ALU_SUB;
            PCSrc   = 1'b1;
            PCWrite = zero;
          end else begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_ADD;
          end
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = isLoad;
          MemWrite = isStore;
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = isLoad;
        end
        default: begin
        end
      endcase
    end
  end

  assign fault   = faultQ;
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Purpose: directed self-checking bench for multicycle_controller.
// Latency: checks every cycle of each instruction class plus timeout and reset corners.
// Backpressure: mem_ready is driven explicitly per cycle.
`timescale 1ns/1ps
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       resetNb;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc, fault;
  logic [1:0] ALUOp;
  logic [2:0] state_o;
  logic       nbALUSrc, nbMemtoReg, nbRegWrite, nbMemRead, nbMemWrite, nbIorD, nbIRWrite;
  logic       nbPCWrite, nbPCSrc, nbFault;
  logic [1:0] nbALUOp;
  logic [2:0] nbState;

  logic [11:0] strb;
  logic [11:0] nbStrb;

  int vectors     = 0;
  int miscompares = 0;

  // Strobe vector order: {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite}_{ALUOp}_{IorD,IRWrite,PCWrite,PCSrc,fault}
  localparam logic [11:0] NONE   = 12'b00000_00_00000;
  localparam logic [11:0] F_WAIT = 12'b00010_00_00000;
  localparam logic [11:0] F_RDY  = 12'b00010_00_01100;
  localparam logic [11:0] EX_R   = 12'b00000_10_00000;
  localparam logic [11:0] EX_IMM = 12'b10000_00_00000;
  localparam logic [11:0] EX_BR1 = 12'b00000_01_00110;
  localparam logic [11:0] EX_BR0 = 12'b00000_01_00010;
  localparam logic [11:0] MEM_LD = 12'b00010_00_10000;
  localparam logic [11:0] MEM_ST = 12'b00001_00_10000;
  localparam logic [11:0] WB_R   = 12'b00100_00_00000;
  localparam logic [11:0] WB_LD  = 12'b01100_00_00000;
  localparam logic [11:0] FLT    = 12'b00000_00_00001;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] BAD  = 7'b1111111;

  assign strb   = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp,
                   IorD, IRWrite, PCWrite, PCSrc, fault};
  assign nbStrb = {nbALUSrc, nbMemtoReg, nbRegWrite, nbMemRead, nbMemWrite, nbALUOp,
                   nbIorD, nbIRWrite, nbPCWrite, nbPCSrc, nbFault};

  multicycle_controller #(.MEM_TIMEOUT(4), .BRANCH_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ALUOp(ALUOp), .IorD(IorD), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .fault(fault), .state_o(state_o)
  );

  multicycle_controller #(.MEM_TIMEOUT(4), .BRANCH_EN(1'b0)) dutNb (
    .clk(clk), .reset(resetNb), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUSrc(nbALUSrc), .MemtoReg(nbMemtoReg), .RegWrite(nbRegWrite), .MemRead(nbMemRead),
    .MemWrite(nbMemWrite), .ALUOp(nbALUOp), .IorD(nbIorD), .IRWrite(nbIRWrite),
    .PCWrite(nbPCWrite), .PCSrc(nbPCSrc), .fault(nbFault), .state_o(nbState)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, check the main DUT, then advance past the next rising edge
  task automatic cyc(input string tag, input logic [6:0] op, input logic z, input logic rdy,
                     input state_t expState, input logic [11:0] expStrb);
    opcode = op; zero = z; mem_ready = rdy;
    #1;
    chk({tag, " state"}, 12'(state_o), 12'(expState));
    chk({tag, " strobes"}, strb, expStrb);
    @(posedge clk); #1;
  endtask

  // Same, checking the BRANCH_EN=0 instance
  task automatic cycNb(input string tag, input logic [6:0] op, input logic rdy,
                       input state_t expState, input logic [11:0] expStrb);
    opcode = op; zero = 1'b1; mem_ready = rdy;
    #1;
    chk({tag, " state"}, 12'(nbState), 12'(expState));
    chk({tag, " strobes"}, nbStrb, expStrb);
    @(posedge clk); #1;
  endtask

  task automatic pulseReset(input string tag);
    reset = 1'b1;
    #1;
    chk({tag, " state"}, 12'(state_o), 12'(S_FETCH));
    chk({tag, " strobes"}, strb, NONE);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; resetNb = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 12'(state_o), 12'(S_FETCH));
    chk("reset strobes", strb, NONE);
    mem_ready = 1'b1;
    #1;
    chk("reset strobes ready", strb, NONE);
    reset = 1'b0;

    // ADD: FETCH DECODE EXEC WB; live opcode scrambled after DECODE
    cyc("add fetch",  ADD, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("add decode", ADD, 1'b0, 1'b1, S_DECODE, NONE);
    cyc("add exec",   BAD, 1'b1, 1'b1, S_EXEC,   EX_R);
    cyc("add wb",     BAD, 1'b0, 1'b1, S_WB,     WB_R);

    // LW: fetch waits 2, MEM waits 3 -> 10 cycles
    cyc("lw fetch w0", LW, 1'b0, 1'b0, S_FETCH,  F_WAIT);
    cyc("lw fetch w1", LW, 1'b0, 1'b0, S_FETCH,  F_WAIT);
    cyc("lw fetch rd", LW, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("lw decode",   LW, 1'b0, 1'b0, S_DECODE, NONE);
    cyc("lw exec",     BAD, 1'b0, 1'b0, S_EXEC,  EX_IMM);
    cyc("lw mem w0",   BAD, 1'b0, 1'b0, S_MEM,   MEM_LD);
    cyc("lw mem w1",   BAD, 1'b0, 1'b0, S_MEM,   MEM_LD);
    cyc("lw mem w2",   BAD, 1'b0, 1'b0, S_MEM,   MEM_LD);
    cyc("lw mem rd",   BAD, 1'b0, 1'b1, S_MEM,   MEM_LD);
    cyc("lw wb",       BAD, 1'b0, 1'b1, S_WB,    WB_LD);

    // ADDI
    cyc("addi fetch",  ADDI, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("addi decode", ADDI, 1'b0, 1'b1, S_DECODE, NONE);
    cyc("addi exec",   ADD,  1'b0, 1'b1, S_EXEC,   EX_IMM);
    cyc("addi wb",     ADD,  1'b0, 1'b1, S_WB,     WB_R);

    // SW: 4 cycles
    cyc("sw fetch",  SW,  1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("sw decode", SW,  1'b0, 1'b1, S_DECODE, NONE);
    cyc("sw exec",   ADD, 1'b0, 1'b1, S_EXEC,   EX_IMM);
    cyc("sw mem",    ADD, 1'b0, 1'b1, S_MEM,    MEM_ST);

    // BEQ taken then not taken: 3 cycles each
    cyc("beq1 fetch",  BEQ, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("beq1 decode", BEQ, 1'b0, 1'b1, S_DECODE, NONE);
    cyc("beq1 exec",   ADD, 1'b1, 1'b1, S_EXEC,   EX_BR1);
    cyc("beq0 fetch",  BEQ, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("beq0 decode", BEQ, 1'b0, 1'b1, S_DECODE, NONE);
    cyc("beq0 exec",   ADD, 1'b0, 1'b1, S_EXEC,   EX_BR0);

    // Fetch ready arrives when the count equals MEM_TIMEOUT: no fault
    cyc("tob fetch w0", ADD, 1'b0, 1'b0, S_FETCH,  F_WAIT);
    cyc("tob fetch w1", ADD, 1'b0, 1'b0, S_FETCH,  F_WAIT);
    cyc("tob fetch w2", ADD, 1'b0, 1'b0, S_FETCH,  F_WAIT);
    cyc("tob fetch w3", ADD, 1'b0, 1'b0, S_FETCH,  F_WAIT);
    cyc("tob fetch rd", ADD, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("tob decode",   LW,  1'b0, 1'b0, S_DECODE, NONE);
    cyc("tob exec",     LW,  1'b0, 1'b0, S_EXEC,   EX_IMM);
    // Same boundary in MEM
    cyc("tob mem w0",   LW,  1'b0, 1'b0, S_MEM,    MEM_LD);
    cyc("tob mem w1",   LW,  1'b0, 1'b0, S_MEM,    MEM_LD);
    cyc("tob mem w2",   LW,  1'b0, 1'b0, S_MEM,    MEM_LD);
    cyc("tob mem w3",   LW,  1'b0, 1'b0, S_MEM,    MEM_LD);
    cyc("tob mem rd",   LW,  1'b0, 1'b1, S_MEM,    MEM_LD);
    cyc("tob wb",       LW,  1'b0, 1'b0, S_WB,     WB_LD);

    // SW interrupted by reset while waiting in MEM
    cyc("swr fetch",  SW,  1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("swr decode", SW,  1'b0, 1'b1, S_DECODE, NONE);
    cyc("swr exec",   SW,  1'b0, 1'b0, S_EXEC,   EX_IMM);
    mem_ready = 1'b0;
    #1;
    chk("swr mem strobes", strb, MEM_ST);
    reset = 1'b1;
    #1;
    chk("swr async state", 12'(state_o), 12'(S_FETCH));
    chk("swr async strobes", strb, NONE);
    @(posedge clk); #1;
    chk("swr held strobes", strb, NONE);
    reset = 1'b0;

    // Fetch timeout: ready never arrives -> FAULT, sticky
    cyc("to fetch w0", ADD, 1'b0, 1'b0, S_FETCH, F_WAIT);
    cyc("to fetch w1", ADD, 1'b0, 1'b0, S_FETCH, F_WAIT);
    cyc("to fetch w2", ADD, 1'b0, 1'b0, S_FETCH, F_WAIT);
    cyc("to fetch w3", ADD, 1'b0, 1'b0, S_FETCH, F_WAIT);
    cyc("to fetch w4", ADD, 1'b0, 1'b0, S_FETCH, F_WAIT);
    cyc("to fault0",   ADD, 1'b1, 1'b1, S_FAULT, FLT);
    cyc("to fault1",   ADD, 1'b1, 1'b1, S_FAULT, FLT);
    pulseReset("to clear");

    // Illegal opcode
    cyc("ill fetch",  BAD, 1'b0, 1'b1, S_FETCH,  F_RDY);
    cyc("ill decode", BAD, 1'b0, 1'b1, S_DECODE, NONE);
    cyc("ill fault0", ADD, 1'b0, 1'b1, S_FAULT,  FLT);
    cyc("ill fault1", ADD, 1'b0, 1'b1, S_FAULT,  FLT);
    pulseReset("ill clear");

    // BEQ on the BRANCH_EN=0 instance is illegal
    reset   = 1'b1;
    resetNb = 1'b0;
    cycNb("nb fetch",  BEQ, 1'b1, S_FETCH,  F_RDY);
    cycNb("nb decode", BEQ, 1'b1, S_DECODE, NONE);
    cycNb("nb fault0", ADD, 1'b1, S_FAULT,  FLT);
    cycNb("nb fault1", ADD, 1'b1, S_FAULT,  FLT);
    resetNb = 1'b1;
    #1;
    chk("nb clear state", 12'(nbState), 12'(S_FETCH));
    chk("nb clear strobes", nbStrb, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
